// File: rtl/bcd_key_to_binary_pkg.sv
// Shared definitions for the keypad-to-binary entry path: key codes, FSM states
// and the 8-bit two's-complement saturation limits.
package bcd_key_to_binary_pkg;

    localparam logic [3:0] KEY_MINUS = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_BKSP  = 4'hD;

    localparam logic [7:0] SAT_POS = 8'h7F;
    localparam logic [7:0] SAT_NEG = 8'h80;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_CONV  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_key_to_binary_sub3.sv
// Reverse double-dabble correction cell: after a right shift, any BCD nibble that
// reached 8 or more carries a borrowed half-ten and is corrected by subtracting 3.
module bcd_sub3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_key_to_binary.sv
// Keypad digit entry buffer with sequential BCD-to-binary conversion and 8-bit
// saturating signed output. Define BACKSPACE_EN to enable key 0xD as backspace.
module bcd_key_to_binary
    import bcd_key_to_binary_pkg::*;
#(
    parameter int NDIG  = 3,
    parameter int BIN_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              key_ready,
    output logic [4*NDIG-1:0] bcd_disp,
    output logic              neg_disp,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              ovf
);

    localparam int BCD_W = 4 * NDIG;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int IT_W  = $clog2(BIN_W);

    state_t           state;
    logic [BCD_W-1:0] bcd_buf;
    logic [CNT_W-1:0] count;
    logic             neg;
    logic [SH_W-1:0]  shifter;
    logic [SH_W-1:0]  shifted;
    logic [SH_W-1:0]  shift_next;
    logic [IT_W-1:0]  iter;
    logic [BIN_W-1:0] mag;
    logic [7:0]       mag_neg;

    // One conversion step: shift the combined register right, then correct each BCD digit.
    assign shifted = shifter >> 1;
    assign shift_next[BIN_W-1:0] = shifted[BIN_W-1:0];

    for (genvar g = 0; g < NDIG; g++) begin : g_sub3
        bcd_sub3 u_sub3 (
            .din  (shifted[BIN_W + 4*g +: 4]),
            .dout (shift_next[BIN_W + 4*g +: 4])
        );
    end

    assign mag     = shifter[BIN_W-1:0];
    assign mag_neg = ~mag[7:0] + 8'd1;

    assign key_ready = (state == ST_ENTRY);
    assign bcd_disp  = bcd_buf;
    assign neg_disp  = neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ENTRY;
            bcd_buf    <= '0;
            count      <= '0;
            neg        <= 1'b0;
            shifter    <= '0;
            iter       <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            if (count != CNT_W'(NDIG)) begin
                                bcd_buf <= {bcd_buf[BCD_W-5:0], key_code};
                                count   <= count + 1'b1;
                            end
                        end else begin
                            case (key_code)
                                KEY_MINUS: neg <= ~neg;
                                KEY_CLEAR: begin
                                    bcd_buf <= '0;
                                    count   <= '0;
                                    neg     <= 1'b0;
                                end
                                KEY_ENTER: begin
                                    if (count != '0) begin
                                        shifter <= {bcd_buf, {BIN_W{1'b0}}};
                                        iter    <= '0;
                                        state   <= ST_CONV;
                                    end
                                end
`ifdef BACKSPACE_EN
                                KEY_BKSP: begin
                                    if (count != '0) begin
                                        bcd_buf <= {4'h0, bcd_buf[BCD_W-1:4]};
                                        count   <= count - 1'b1;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                ST_CONV: begin
                    shifter <= shift_next;
                    iter    <= iter + 1'b1;
                    if (iter == IT_W'(BIN_W - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The negative limit is one larger in magnitude than the positive one.
                    if (!neg) begin
                        if (mag > BIN_W'(SAT_POS)) begin
                            data_out <= SAT_POS;
                            ovf      <= 1'b1;
                        end else begin
                            data_out <= mag[7:0];
                            ovf      <= 1'b0;
                        end
                    end else begin
                        if (mag > BIN_W'(SAT_NEG)) begin
                            data_out <= SAT_NEG;
                            ovf      <= 1'b1;
                        end else begin
                            data_out <= mag_neg;
                            ovf      <= 1'b0;
                        end
                    end
                    data_valid <= 1'b1;
                    bcd_buf    <= '0;
                    count      <= '0;
                    neg        <= 1'b0;
                    state      <= ST_ENTRY;
                end
                default: state <= ST_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_key_to_binary.sv
// Self-checking bench for bcd_key_to_binary: directed keystroke sequences plus
// random ones, compared against a decimal-arithmetic model of the entry buffer.
module tb_bcd_key_to_binary;

    localparam int NDIG  = 3;
    localparam int BIN_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [11:0] bcd_disp;
    logic        neg_disp;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    int mdl_q[$];
    bit mdl_neg;

    always #5 clk = ~clk;

    bcd_key_to_binary #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .bcd_disp   (bcd_disp),
        .neg_disp   (neg_disp),
        .data_out   (data_out),
        .data_valid (data_valid),
        .ovf        (ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] modelDisp();
        logic [11:0] d;
        d = '0;
        foreach (mdl_q[i]) d = {d[7:0], 4'(mdl_q[i])};
        return d;
    endfunction

    function automatic void modelClear();
        mdl_q.delete();
        mdl_neg = 1'b0;
    endfunction

    function automatic void modelKey(input logic [3:0] code);
        if (code <= 4'd9) begin
            if (mdl_q.size() < NDIG) mdl_q.push_back(int'(code));
        end else if (code == 4'hA) begin
            mdl_neg = ~mdl_neg;
        end else if (code == 4'hC) begin
            modelClear();
        end
`ifdef BACKSPACE_EN
        else if (code == 4'hD) begin
            if (mdl_q.size() > 0) void'(mdl_q.pop_back());
        end
`endif
    endfunction

    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        if (code != 4'hB) begin
            modelKey(code);
            checkOutput("bcd_disp_echo", 32'(bcd_disp), 32'(modelDisp()));
            checkOutput("neg_disp_echo", 32'(neg_disp), 32'(mdl_neg));
        end
    endtask

    task automatic keySeq(input logic [3:0] codes[$]);
        foreach (codes[i]) applyStimulus(codes[i]);
    endtask

    // Press enter, optionally inject digit strobes while converting, and check the result.
    task automatic runEnter(input string tag, input int inject);
        int  v;
        int  exp_d;
        bit  exp_o;
        bit  expect_valid;
        bit  seen;
        int  n;
        v = 0;
        foreach (mdl_q[i]) v = v * 10 + mdl_q[i];
        if (!mdl_neg) begin
            exp_d = (v > 127) ? 127 : v;
            exp_o = (v > 127);
        end else begin
            exp_d = (v > 128) ? 128 : (256 - v) % 256;
            exp_o = (v > 128);
        end
        expect_valid = (mdl_q.size() > 0);
        applyStimulus(4'hB);
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            key_valid = (k <= inject);
            key_code  = 4'($urandom_range(0, 9));
            if (k == 3 && expect_valid) checkOutput({tag, "_key_ready_conv"}, 32'(key_ready), 32'd0);
            if (data_valid) begin
                seen = 1'b1;
                n    = k;
                break;
            end
        end
        key_valid = 1'b0;
        if (expect_valid) begin
            checkOutput({tag, "_valid_seen"}, 32'(seen), 32'd1);
            checkOutput({tag, "_latency"}, 32'(n), 32'(BIN_W + 1));
            checkOutput({tag, "_data_out"}, 32'(data_out), 32'(exp_d));
            checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
            checkOutput({tag, "_bcd_cleared"}, 32'(bcd_disp), 32'd0);
            checkOutput({tag, "_neg_cleared"}, 32'(neg_disp), 32'd0);
            checkOutput({tag, "_key_ready_back"}, 32'(key_ready), 32'd1);
            @(negedge clk);
            checkOutput({tag, "_pulse_width"}, 32'(data_valid), 32'd0);
            checkOutput({tag, "_data_held"}, 32'(data_out), 32'(exp_d));
            modelClear();
        end else begin
            checkOutput({tag, "_no_valid"}, 32'(seen), 32'd0);
            checkOutput({tag, "_key_ready_idle"}, 32'(key_ready), 32'd1);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_data_out"}, 32'(data_out), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
        checkOutput({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        checkOutput({tag, "_key_ready"}, 32'(key_ready), 32'd1);
        checkOutput({tag, "_bcd_disp"}, 32'(bcd_disp), 32'd0);
        checkOutput({tag, "_neg_disp"}, 32'(neg_disp), 32'd0);
    endtask

    initial begin
        bit seen;
        int nk;
        int r;
        logic [3:0] code;

        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        modelClear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetState("reset");

        keySeq('{4'h1, 4'h2, 4'h3});
        runEnter("pos_123", 0);

        keySeq('{4'hA, 4'h1, 4'h2, 4'h8});
        runEnter("neg_128", 0);
        keySeq('{4'hA, 4'h0});
        runEnter("neg_zero", 0);

        keySeq('{4'h2, 4'h5, 4'h5});
        runEnter("sat_pos_255", 0);
        keySeq('{4'hA, 4'h2, 4'h0, 4'h0});
        runEnter("sat_neg_200", 0);
        keySeq('{4'h9, 4'h9, 4'h9});
        runEnter("sat_pos_999", 0);

        keySeq('{4'h0, 4'h4, 4'h2, 4'h7});
        runEnter("fourth_dropped", 0);
        applyStimulus(4'hC);
        runEnter("enter_empty", 0);
        keySeq('{4'h5, 4'hC, 4'h6});
        runEnter("clear_then_6", 0);

        keySeq('{4'h1, 4'h2, 4'h3});
        runEnter("conv_inject", 5);

        keySeq('{4'h1, 4'h2, 4'hD, 4'h5});
        runEnter("backspace", 0);

        keySeq('{4'h5, 4'h0});
        runEnter("pre_abort", 0);
        keySeq('{4'hA, 4'h1, 4'h2, 4'h3});
        applyStimulus(4'hB);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelClear();
        checkResetState("abort");
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (data_valid) seen = 1'b1;
        end
        checkOutput("abort_no_valid", 32'(seen), 32'd0);

        for (int it = 0; it < 30; it++) begin
            nk = $urandom_range(1, 6);
            for (int j = 0; j < nk; j++) begin
                r = $urandom_range(0, 99);
                if (r < 65)      code = 4'($urandom_range(0, 9));
                else if (r < 75) code = 4'hA;
                else if (r < 80) code = 4'hC;
                else if (r < 90) code = 4'hD;
                else             code = 4'(14 + r % 2);
                applyStimulus(code);
            end
            runEnter("random", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_key_to_binary.md
Name: bcd_key_to_binary

Overview:
Inverse path of the signed-binary-to-BCD display chain. Accepts decimal keystrokes (digits, minus, enter, clear) from the keypad scan logic and holds up to NDIG BCD digits plus a sign, exposing them for echo on the 7-segment display. On enter, a sequential reverse double-dabble converter (shift right, subtract 3) turns the BCD buffer into binary. The block then emits an 8-bit two's-complement value with saturation and an overflow flag.

Parameters:
NDIG, 3, number of BCD digits buffered.
BIN_W, 10, converter binary width and iteration count; must satisfy 2^BIN_W > 10^NDIG-1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_valid  in  1  key_code valid this cycle (single-cycle strobe per keystroke)
key_code  in  4  0x0-0x9 digit, 0xA minus-toggle, 0xB enter, 0xC clear, 0xD backspace, 0xE/0xF reserved
key_ready  out  1  high only in ENTRY; strobes while low are dropped
bcd_disp  out  4*NDIG  buffered digits, least-significant digit in [3:0]
neg_disp  out  1  current sign for the display minus indicator
data_out  out  8  converted two's-complement result, held until next result
data_valid  out  1  one-cycle pulse when data_out/ovf update
ovf  out  1  result saturated; held with data_out

Behaviour:
- Reset values: state ENTRY, bcd_disp 0, digit count 0, neg_disp 0, data_out 0x00, data_valid 0, ovf 0, key_ready 1. Reset mid-conversion aborts the conversion; no data_valid is produced.
- States: ENTRY -> CONV -> DONE -> ENTRY.
- ENTRY, on key_valid:
  - digit: if count<NDIG, bcd_disp <= {bcd_disp[lower digits], d}, count++; if count==NDIG the digit is ignored.
  - 0xA: toggles neg_disp.
  - 0xC: zeroes buffer, count and sign.
  - 0xB with count==0: ignored.
  - 0xB with count>0: load shifter {bcd_disp, BIN_W'b0}, iteration counter 0, go to CONV.
  - 0xE/0xF, and 0xD without the macro: ignored.
- CONV, each cycle:
  - Shift the whole {bcd, bin} register right by 1.
  - Pass every BCD nibble through sub3: value >=8 becomes value-3.
  - After BIN_W iterations (counter == BIN_W-1), go to DONE.
- DONE, single cycle; M = binary magnitude:
  - Positive, M<=127: data_out=M, ovf=0.
  - Positive, M>127: data_out=0x7F, ovf=1.
  - Negative, M<=128: data_out=-M mod 256, ovf=0. Negative zero gives 0x00.
  - Negative, M>128: data_out=0x80, ovf=1.
  - data_valid=1 for this cycle; buffer, count and sign cleared; return to ENTRY.
- Latency: enter sampled at edge E; data_valid is high during the cycle after edge E+BIN_W+1, i.e. 11 edges later at default BIN_W. key_ready is low from edge E+1 until return to ENTRY.
- bcd_disp is unchanged during CONV; the shifter is a separate register.

Optional Feature:
BACKSPACE_EN
- Defined: 0xD in ENTRY with count>0 shifts the buffer right one digit, zero-fills the top digit, count--. With count==0 it is ignored; the sign is unaffected.
- Undefined: 0xD is ignored like the reserved codes.

Decomposition:
- Shared package: key-code constants (KEY_MINUS=0xA, KEY_ENTER=0xB, KEY_CLEAR=0xC, KEY_BKSP=0xD), the ENTRY/CONV/DONE state encoding, and the saturation limits 0x7F/0x80.
- One sub-module, bcd_sub3: 4-bit combinational, in>=8 ? in-3 : in. It is instantiated NDIG times, mirroring the existing add3 cell.

Test Plan:
1. Keys 1,2,3,B -> data_out 0x7B, ovf 0, data_valid exactly one cycle, 11 edges after enter; bcd_disp back to 0.
2. Keys A,1,2,8,B -> 0x80, ovf 0. Keys A,0,B -> 0x00, ovf 0.
3. Keys 2,5,5,B -> 0x7F, ovf 1. Keys A,2,0,0,B -> 0x80, ovf 1. Keys 9,9,9,B -> 0x7F, ovf 1.
4. Keys 0,4,2,7,B -> fourth digit dropped, 0x2A. Keys C then B -> no data_valid. Keys 5,C,6,B -> 0x06.
5. Digit strobes during CONV -> ignored, result unchanged. rst asserted at 5th CONV cycle -> no data_valid, all outputs at reset values.
6. Keys 1,2,D,5,B -> 0x0F with BACKSPACE_EN defined; 0x7D (125) without it.
